// File: rtl/decoder_sweep_sequencer.sv
// Sweep sequencer that drives the enable/select pair of a 4:16 decoder.
// Steps dec_in from a latched first address to a latched last address, with per-address dwell or step-wait.
module decoder_sweep_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               step_mode,
  input  logic               step,
  input  logic [ADDR_W-1:0]  first,
  input  logic [ADDR_W-1:0]  last,
  input  logic [DWELL_W-1:0] dwell,
  output logic               dec_enable,
  output logic [ADDR_W-1:0]  dec_in,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HOLD   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  dec_in_q, dec_in_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]  last_q, last_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               step_mode_q, step_mode_d;

  logic               expiry_s;
  logic               at_last_s;

  // dwell_q is never zero (zero is promoted to one at latch time), so the subtraction cannot wrap
  assign expiry_s  = (cnt_q == (dwell_q - DWELL_ONE));
  assign at_last_s = (dec_in_q == last_q);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    dec_in_d    = dec_in_q;
    en_d        = en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    cnt_d       = cnt_q;
    last_d      = last_q;
    dwell_d     = dwell_q;
    step_mode_d = step_mode_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          last_d      = last;
          dwell_d     = (dwell == {DWELL_W{1'b0}}) ? DWELL_ONE : dwell;
          step_mode_d = step_mode;
          dec_in_d    = first;
          en_d        = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = {DWELL_W{1'b0}};
          state_d     = S_RUN;
        end else begin
          en_d        = 1'b0;
          busy_d      = 1'b0;
        end
      end

      S_RUN: begin
        if (stop) begin
          en_d      = 1'b0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
          cnt_d     = {DWELL_W{1'b0}};
          state_d   = S_IDLE;
        end else if (expiry_s) begin
          cnt_d = {DWELL_W{1'b0}};
          if (step_mode_q) begin
            state_d = S_HOLD;
          end else if (at_last_s) begin
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            dec_in_d = dec_in_q + ADDR_ONE;
          end
        end else begin
          cnt_d = cnt_q + DWELL_ONE;
        end
      end

      S_HOLD: begin
        if (stop) begin
          en_d      = 1'b0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
          cnt_d     = {DWELL_W{1'b0}};
          state_d   = S_IDLE;
        end else if (step) begin
          cnt_d = {DWELL_W{1'b0}};
          if (at_last_s) begin
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            dec_in_d = dec_in_q + ADDR_ONE;
            state_d  = S_RUN;
          end
        end else begin
          state_d = S_HOLD;
        end
      end

      S_FINISH: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = {DWELL_W{1'b0}};
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dec_in_q    <= {ADDR_W{1'b0}};
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cnt_q       <= {DWELL_W{1'b0}};
      last_q      <= {ADDR_W{1'b0}};
      dwell_q     <= DWELL_ONE;
      step_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dec_in_q    <= dec_in_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      dwell_q     <= dwell_d;
      step_mode_q <= step_mode_d;
    end
  end

  assign dec_enable = en_q;
  assign dec_in     = dec_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_decoder_sweep_sequencer.sv
// Self-checking bench for decoder_sweep_sequencer: table of auto sweeps plus hand-written step/stop/reset sequences.
module tb_decoder_sweep_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, step_mode, step;
  logic [3:0] first, last;
  logic [7:0] dwell;
  logic       dec_enable;
  logic [3:0] dec_in;
  logic       busy, done, aborted;

  int chk_cnt = 0;
  int err_cnt = 0;

  typedef struct packed {
    logic       en;
    logic [3:0] din;
    logic       din_care;
    logic       busy;
    logic       done;
    logic       aborted;
  } exp_t;

  typedef struct {
    logic [3:0] first;
    logic [3:0] last;
    logic [7:0] dwell;
    int         n_addr;
    int         en_cycles;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[5];

  decoder_sweep_sequencer #(.ADDR_W(4), .DWELL_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .step_mode  (step_mode),
    .step       (step),
    .first      (first),
    .last       (last),
    .dwell      (dwell),
    .dec_enable (dec_enable),
    .dec_in     (dec_in),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic en, input logic [3:0] din, input logic care,
                      input logic b, input logic d, input logic a);
    exp_t e;
    e.en = en; e.din = din; e.din_care = care; e.busy = b; e.done = d; e.aborted = a;
    sb_q.push_back(e);
  endtask

  task automatic check_next(input string name);
    exp_t e;
    chk_cnt++;
    if (sb_q.size() == 0) begin
      err_cnt++;
      $display("FAIL %s: scoreboard empty at t=%0t", name, $time);
    end else begin
      e = sb_q.pop_front();
      if (dec_enable !== e.en || busy !== e.busy || done !== e.done || aborted !== e.aborted ||
          (e.din_care && dec_in !== e.din)) begin
        err_cnt++;
        $display("FAIL %s t=%0t: got en=%b din=%0d busy=%b done=%b aborted=%b, expected en=%b din=%0d(care=%b) busy=%b done=%b aborted=%b",
                 name, $time, dec_enable, dec_in, busy, done, aborted,
                 e.en, e.din, e.din_care, e.busy, e.done, e.aborted);
      end
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    chk_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int         deff;
    int         en_seen;
    logic [3:0] a;
    bit         first_iter;

    // first, last, dwell, addresses in sweep, enable-high cycles
    vecs[0] = '{4'd0,  4'd15, 8'd1, 16, 16};
    vecs[1] = '{4'd14, 4'd1,  8'd3, 4,  12};
    vecs[2] = '{4'd5,  4'd5,  8'd0, 1,  1};
    vecs[3] = '{4'd9,  4'd7,  8'd1, 15, 15};
    vecs[4] = '{4'd3,  4'd4,  8'd5, 2,  10};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; step_mode = 1'b0; step = 1'b0;
    first = 4'd0; last = 4'd0; dwell = 8'd0;
    #2;
    push(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_next("reset_state");
    cyc();
    rst_n = 1'b1;
    cyc();

    // stop and step have no effect in IDLE
    stop = 1'b1; step = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      push(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_next("idle_ignores_stop_step");
    end
    stop = 1'b0; step = 1'b0;

    // auto-mode sweeps from the table
    for (int v = 0; v < 5; v++) begin
      first = vecs[v].first; last = vecs[v].last; dwell = vecs[v].dwell;
      step_mode = 1'b0; start = 1'b1;
      deff = (vecs[v].dwell == 8'd0) ? 1 : int'(vecs[v].dwell);
      for (int k = 0; k < vecs[v].n_addr; k++) begin
        a = vecs[v].first + 4'(k);
        for (int j = 0; j < deff; j++) push(1'b1, a, 1'b1, 1'b1, 1'b0, 1'b0);
      end
      push(1'b0, vecs[v].last, 1'b1, 1'b0, 1'b1, 1'b0);
      push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      en_seen = 0;
      first_iter = 1'b1;
      while (sb_q.size() > 0) begin
        cyc();
        if (first_iter) begin
          start = 1'b0;
          first = ~vecs[v].first; last = ~vecs[v].last; dwell = 8'd200; step_mode = 1'b1;
          first_iter = 1'b0;
        end
        if (dec_enable === 1'b1) en_seen++;
        check_next($sformatf("auto_sweep_%0d", v));
      end
      check_val($sformatf("auto_en_cycles_%0d", v), en_seen, vecs[v].en_cycles);
      step_mode = 1'b0;
    end

    // step mode: 2..4, dwell 2, step ten cycles after each HOLD entry; an early step in RUN is ignored
    first = 4'd2; last = 4'd4; dwell = 8'd2; step_mode = 1'b1; start = 1'b1;
    for (int ad = 2; ad <= 4; ad++) begin
      for (int i = 0; i < 12; i++) begin
        cyc();
        start = 1'b0;
        step  = 1'b0;
        push(1'b1, 4'(ad), 1'b1, 1'b1, 1'b0, 1'b0);
        check_next($sformatf("step_mode_addr%0d_c%0d", ad, i));
        if (i == 0 || i == 11) step = 1'b1;
      end
    end
    cyc();
    step = 1'b0; step_mode = 1'b0;
    push(1'b0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    check_next("step_mode_done");
    cyc();
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_next("step_mode_idle");

    // stop at the third address, same cycle as its dwell expiry
    first = 4'd0; last = 4'd15; dwell = 8'd2; start = 1'b1;
    for (int e = 0; e < 6; e++) begin
      cyc();
      start = 1'b0;
      push(1'b1, 4'(e / 2), 1'b1, 1'b1, 1'b0, 1'b0);
      check_next($sformatf("stop_pre_%0d", e));
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_next("stop_aborted");
    for (int i = 0; i < 3; i++) begin
      cyc();
      push(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_next("stop_after_no_done");
    end

    // start held while busy, then asynchronous reset mid-sweep
    first = 4'd0; last = 4'd15; dwell = 8'd4; start = 1'b1;
    cyc();
    first = 4'd8;
    push(1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_next("busy_start_0");
    for (int i = 1; i < 5; i++) begin
      cyc();
      if (i == 2) start = 1'b0;
      push(1'b1, (i < 4) ? 4'd0 : 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      check_next($sformatf("busy_start_%0d", i));
    end
    #3;
    rst_n = 1'b0;
    #1;
    push(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_next("async_reset_immediate");
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      push(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_next("after_reset_quiet");
    end

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
